// File: rtl/cache_definitions_pkg.sv
// cache_definitions_pkg: shared cache types and tree pseudo-LRU helpers
package cache_definitions_pkg;
  typedef enum logic [1:0] {OP_RD, OP_WR, OP_FILL, OP_INVAL} tag_op_e;
  typedef enum logic {ST_CLEAR, ST_IDLE} tag_state_e;
  localparam int SA_TAG_W = 18;
  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [SA_TAG_W-1:0] tag;
  } sa_tag_entry_t;
  // Trees up to 8 ways (7 heap-ordered nodes); lv is the tree depth
  function automatic logic [2:0] plru_victim(input logic [6:0] bits, input int lv);
    logic [2:0] n;
    logic [2:0] w;
    n = '0;
    w = '0;
    for (int l = 0; l < 3; l++)
      if (l < lv) begin
        w = {w[1:0], bits[n]};
        n = {n[1:0], 1'b0} + 3'd1 + {2'b0, bits[n]};
      end
    return w;
  endfunction
  function automatic logic [6:0] plru_touch(input logic [6:0] bits, input logic [2:0] way, input int lv);
    logic [6:0] t;
    logic [2:0] n;
    logic [2:0] wa;
    logic       b;
    t = bits;
    n = '0;
    wa = way << (3 - lv);
    for (int l = 0; l < 3; l++)
      if (l < lv) begin
        b = wa[2];
        wa = wa << 1;
        t[n] = ~b;
        n = {n[1:0], 1'b0} + 3'd1 + {2'b0, b};
      end
    return t;
  endfunction
endpackage

// File: rtl/sa_cache_tag_plru_tree.sv
// plru_tree: combinational victim pick and touch update for one set's PLRU tree
module plru_tree
  import cache_definitions_pkg::*;
#(
  parameter int WAYS = 4
) (
  input  logic [WAYS-2:0]         bits,
  input  logic [$clog2(WAYS)-1:0] touch_way,
  output logic [$clog2(WAYS)-1:0] victim,
  output logic [WAYS-2:0]         touched
);
  localparam int WAY_W = $clog2(WAYS);
  assign victim  = WAY_W'(plru_victim(7'(bits), WAY_W));
  assign touched = (WAYS-1)'(plru_touch(7'(bits), 3'(touch_way), WAY_W));
endmodule

// File: rtl/sa_cache_tag.sv
// sa_cache_tag: set-associative tag array with tree PLRU, dirty tracking and clear sweep
module sa_cache_tag
  import cache_definitions_pkg::*;
#(
  parameter int WAYS  = 4,
  parameter int SETS  = 256,
  parameter int TAG_W = 18,
  parameter int IDX_W = $clog2(SETS),
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [IDX_W-1:0] req_index,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             req_dirty,
  output logic             rsp_valid,
  output logic             rsp_hit,
  output logic [WAY_W-1:0] rsp_way,
  output logic             rsp_evict,
  output logic             rsp_evict_dirty,
  output logic [TAG_W-1:0] rsp_evict_tag,
  output logic             init_busy
);
  typedef struct packed {
    logic             valid;
    logic             dirty;
    logic [TAG_W-1:0] tag;
  } entry_t;
  entry_t           mem [WAYS][SETS];
  logic [WAYS-2:0]  plru [SETS];
  tag_state_e       state, state_nxt;
  logic [IDX_W-1:0] clr_idx;
  tag_op_e          op;
  logic             accept, hit, inv_any, evict;
  logic [WAYS-1:0]  hit_vec;
  logic [WAY_W-1:0] hit_way, inv_way, plru_way, tgt_way;
  logic [WAYS-2:0]  plru_new;
  entry_t           victim_e;
  assign op     = tag_op_e'(req_op);
  assign accept = req_valid && req_ready;
  always_ff @(posedge clk) state <= reset ? ST_CLEAR : state_nxt;
  always_comb state_nxt = (state == ST_CLEAR && clr_idx == IDX_W'(SETS-1)) ? ST_IDLE : state;
  always_comb begin
    req_ready = state == ST_IDLE;
    init_busy = state == ST_CLEAR;
  end
  always_ff @(posedge clk)
    if (reset) clr_idx <= '0;
    else if (init_busy) clr_idx <= clr_idx + 1'b1;
  // Descending scan so the lowest-numbered matching/invalid way wins
  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    inv_any = 1'b0;
    for (int w = WAYS-1; w >= 0; w--) begin
      hit_vec[w] = mem[w][req_index].valid && mem[w][req_index].tag == req_tag;
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!mem[w][req_index].valid) begin
        inv_way = WAY_W'(w);
        inv_any = 1'b1;
      end
    end
    hit      = |hit_vec;
    tgt_way  = hit ? hit_way : inv_any ? inv_way : plru_way;
    victim_e = mem[tgt_way][req_index];
    evict    = op == OP_FILL && !hit && victim_e.valid;
  end
  plru_tree #(.WAYS(WAYS)) u_plru (
    .bits      (plru[req_index]),
    .touch_way (tgt_way),
    .victim    (plru_way),
    .touched   (plru_new)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      if (init_busy) begin
        for (int w = 0; w < WAYS; w++) mem[w][clr_idx] <= '0;
        plru[clr_idx] <= '0;
      end else if (accept) begin
        if ((hit && op != OP_INVAL) || op == OP_FILL) plru[req_index] <= plru_new;
        if (op == OP_FILL) mem[tgt_way][req_index] <= {1'b1, req_dirty, req_tag};
        else if (hit && op == OP_WR) mem[hit_way][req_index].dirty <= 1'b1;
        else if (hit && op == OP_INVAL) begin
          mem[hit_way][req_index].valid <= 1'b0;
          mem[hit_way][req_index].dirty <= 1'b0;
        end
      end
    end
  always_ff @(posedge clk)
    if (reset) begin
      rsp_valid       <= 1'b0;
      rsp_hit         <= 1'b0;
      rsp_way         <= '0;
      rsp_evict       <= 1'b0;
      rsp_evict_dirty <= 1'b0;
      rsp_evict_tag   <= '0;
    end else begin
      rsp_valid <= accept;
      if (accept) begin
        rsp_hit         <= hit;
        rsp_way         <= tgt_way;
        rsp_evict       <= evict;
        rsp_evict_dirty <= evict && victim_e.dirty;
        rsp_evict_tag   <= evict ? victim_e.tag : '0;
      end
    end
endmodule

// File: tb/tb_sa_cache_tag.sv
// tb_sa_cache_tag: random and directed stimulus against a set-level behavioural cache model
module tb_sa_cache_tag;
  localparam int WAYS = 4;
  localparam int SETS = 16;
  localparam logic [1:0] RD = 2'd0, WR = 2'd1, FILL = 2'd2, INVAL = 2'd3;
  logic       clk = 1'b0;
  logic       reset, req_valid, req_ready, req_dirty;
  logic [1:0] req_op;
  logic [3:0] req_index;
  logic [7:0] req_tag;
  logic       rsp_valid, rsp_hit, rsp_evict, rsp_evict_dirty, init_busy;
  logic [1:0] rsp_way;
  logic [7:0] rsp_evict_tag;
  int n_chk = 0, n_err = 0;
  bit mv [SETS][WAYS];
  bit md [SETS][WAYS];
  int mt [SETS][WAYS];
  int pl [SETS][3];
  int clr_left = 0, e_way = 0, e_evt = 0;
  bit started = 0, in_rst = 0, e_valid = 0, e_hit = 0, e_ev = 0, e_evd = 0, e_wchk = 0;

  sa_cache_tag #(.WAYS(WAYS), .SETS(SETS), .TAG_W(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_index(req_index), .req_tag(req_tag), .req_dirty(req_dirty),
    .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_way(rsp_way), .rsp_evict(rsp_evict),
    .rsp_evict_dirty(rsp_evict_dirty), .rsp_evict_tag(rsp_evict_tag), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Tree nodes: [0] root, [1] chooses among ways 0/1, [2] among ways 2/3; 1 = victim on the high side
  function automatic void touch(input int s, input int w);
    pl[s][0] = (w < 2) ? 1 : 0;
    if (w < 2) pl[s][1] = (w == 0) ? 1 : 0;
    else pl[s][2] = (w == 2) ? 1 : 0;
  endfunction

  function automatic int pvic(input int s);
    return (pl[s][0] == 0) ? ((pl[s][1] != 0) ? 1 : 0) : ((pl[s][2] != 0) ? 3 : 2);
  endfunction

  task automatic model_access();
    int s, hw, vw;
    s = int'(req_index);
    hw = -1;
    for (int w = 0; w < WAYS; w++) if (hw < 0 && mv[s][w] && mt[s][w] == int'(req_tag)) hw = w;
    e_valid = 1; e_hit = hw >= 0; e_ev = 0; e_evd = 0; e_evt = 0; e_wchk = e_hit; e_way = hw;
    case (req_op)
      RD, WR: if (e_hit) begin
        touch(s, hw);
        if (req_op == WR) md[s][hw] = 1;
      end
      FILL: begin
        vw = hw;
        for (int w = 0; w < WAYS; w++) if (vw < 0 && !mv[s][w]) vw = w;
        if (vw < 0) vw = pvic(s);
        e_ev = !e_hit && mv[s][vw];
        e_evd = e_ev && md[s][vw];
        e_evt = mt[s][vw];
        mv[s][vw] = 1; md[s][vw] = req_dirty; mt[s][vw] = int'(req_tag);
        touch(s, vw);
        e_way = vw; e_wchk = 1;
      end
      default: if (e_hit) begin
        mv[s][hw] = 0;
        md[s][hw] = 0;
      end
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      started = 1; in_rst = 1; clr_left = SETS;
      e_valid = 0; e_hit = 0; e_ev = 0; e_evd = 0; e_way = 0; e_evt = 0; e_wchk = 0;
      foreach (mv[s, w]) begin mv[s][w] = 0; md[s][w] = 0; end
      foreach (pl[s, n]) pl[s][n] = 0;
    end else if (started) begin
      in_rst = 0;
      e_valid = 0;
      if (clr_left > 0) clr_left--;
      else if (req_valid) model_access();
    end
  end

  always @(negedge clk) if (started) begin
    chk("req_ready", req_ready, clr_left == 0);
    chk("init_busy", init_busy, clr_left != 0);
    chk("rsp_valid", rsp_valid, e_valid);
    chk("rsp_hit", rsp_hit, e_hit);
    chk("rsp_evict", rsp_evict, e_ev);
    if (e_valid && e_wchk) chk("rsp_way", rsp_way, e_way);
    if (e_ev) begin
      chk("rsp_evict_dirty", rsp_evict_dirty, e_evd);
      chk("rsp_evict_tag", rsp_evict_tag, e_evt);
    end
    if (in_rst) begin
      chk("rst_way", rsp_way, 0);
      chk("rst_evict_dirty", rsp_evict_dirty, 0);
      chk("rst_evict_tag", rsp_evict_tag, 0);
    end
  end

  task automatic issue(input logic [1:0] op, input int idx, input logic [7:0] tag, input logic d);
    @(negedge clk);
    req_valid = 1; req_op = op; req_index = 4'(idx); req_tag = tag; req_dirty = d;
    @(negedge clk);
    req_valid = 0;
  endtask

  task automatic wait_clear(input string nm);
    int n;
    n = 0;
    while (init_busy === 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(nm, n, SETS);
    chk("ready_after_clear", req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1; req_valid = 0; req_op = RD; req_index = 0; req_tag = 0; req_dirty = 0;
    repeat (3) @(negedge clk);
    chk("reset_busy", init_busy, 1);
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    reset = 0;
    wait_clear("clear_cycles");
    issue(RD, 3, 8'h10, 0);
    chk("rd_after_clear_valid", rsp_valid, 1);
    chk("rd_after_clear_hit", rsp_hit, 0);
    for (int i = 0; i < 4; i++) begin
      issue(FILL, 5, 8'(8'h10 + i), 0);
      chk("fill_way", rsp_way, i);
      chk("fill_evict", rsp_evict, 0);
    end
    issue(RD, 5, 8'h12, 0);
    chk("rd12_hit", rsp_hit, 1);
    chk("rd12_way", rsp_way, 2);
    issue(RD, 5, 8'h13, 0);
    chk("rd13_way", rsp_way, 3);
    issue(RD, 5, 8'h10, 0);
    chk("rd10_way", rsp_way, 0);
    issue(FILL, 5, 8'h20, 0);
    chk("plru_way", rsp_way, 2);
    chk("plru_evict", rsp_evict, 1);
    chk("plru_evict_tag", rsp_evict_tag, 8'h12);
    issue(WR, 5, 8'h11, 0);
    chk("wr_hit", rsp_hit, 1);
    chk("wr_way", rsp_way, 1);
    issue(RD, 5, 8'h10, 0);
    issue(RD, 5, 8'h13, 0);
    issue(FILL, 5, 8'h40, 0);
    chk("dirty_victim_way", rsp_way, 1);
    chk("dirty_evict", rsp_evict, 1);
    chk("dirty_evict_dirty", rsp_evict_dirty, 1);
    chk("dirty_evict_tag", rsp_evict_tag, 8'h11);
    issue(INVAL, 5, 8'h13, 0);
    chk("inval_hit", rsp_hit, 1);
    issue(FILL, 5, 8'h30, 0);
    chk("refill_way", rsp_way, 3);
    chk("refill_evict", rsp_evict, 0);
    chk("refill_hit", rsp_hit, 0);
    repeat (600) begin
      @(negedge clk);
      req_valid = $urandom_range(0, 3) != 0;
      req_op    = 2'($urandom_range(0, 3));
      req_index = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(4, 6));
      req_tag   = 8'(8'h10 + $urandom_range(0, 7));
      req_dirty = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    req_valid = 1; req_op = RD; req_index = 5; req_tag = 8'h30;
    @(negedge clk);
    chk("midreset_prior_rsp", rsp_valid, 1);
    req_index = 6; reset = 1;
    @(negedge clk);
    chk("midreset_rsp_valid", rsp_valid, 0);
    chk("midreset_busy", init_busy, 1);
    reset = 0; req_valid = 0;
    wait_clear("midreset_clear_cycles");
    for (int s = 0; s < SETS; s++) begin
      issue(RD, s, 8'(8'h10 + (s % 8)), 0);
      chk("post_reset_miss", rsp_hit, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/sa_cache_tag.md
# sa_cache_tag

Parametrised set-associative tag array with per-set tree pseudo-LRU, dirty tracking and a sequential clear engine. It supersedes the single-way tag memory and keeps the data array's index space. It sits between the cache controller FSM and the data array. Each accepted request returns hit/miss, the hit way and victim information one cycle later.

## Interface
- `WAYS`, default 4: associativity; legal values 2, 4, 8.
- `SETS`, default 256: number of sets; power of two, at least 2.
- `TAG_W`, default 18: tag width in bits.
- Derived widths: `IDX_W = $clog2(SETS)`, `WAY_W = $clog2(WAYS)`.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; starts the clear sweep.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high when idle (not clearing); a request is accepted when `req_valid && req_ready`.
- `req_op`  in  2  operation: 00 RD, 01 WR, 10 FILL, 11 INVAL.
- `req_index`  in  IDX_W  set index.
- `req_tag`  in  TAG_W  tag to compare or install.
- `req_dirty`  in  1  dirty value written by FILL.
- `rsp_valid`  out  1  one-cycle pulse, response for the request accepted in the previous cycle.
- `rsp_hit`  out  1  `req_tag` matched a valid way.
- `rsp_way`  out  WAY_W  way that hit, or way filled.
- `rsp_evict`  out  1  FILL displaced a valid line.
- `rsp_evict_dirty`  out  1  the displaced line was dirty.
- `rsp_evict_tag`  out  TAG_W  tag of the displaced line.
- `init_busy`  out  1  clear sweep in progress.

## Operation
- Per-set state: `WAYS` entries of {valid, dirty, tag}, plus `WAYS-1` PLRU tree bits.
- FSM has two states, CLEAR and IDLE.
- **CLEAR**
  - Entered on `reset`.
  - Writes set `clr_idx` to all-zero each cycle, starting at 0 and incrementing by 1.
  - After writing `SETS-1`, moves to IDLE.
  - `req_ready` = 0 and `init_busy` = 1 throughout.
- **IDLE**
  - `req_ready` = 1 and `init_busy` = 0.
  - Tag compare is combinational on the addressed set in the accept cycle.
  - State updates at the end of the accept cycle; response outputs are registered.
- **RD**: reports hit and way. On a hit, PLRU is touched toward the hit way. On a miss, no state changes.
- **WR**: same as RD; on a hit, the way's dirty bit is also set to 1.
- **FILL**
  - If the tag already hits: rewrite that way with dirty=`req_dirty`, touch PLRU, `rsp_hit`=1, `rsp_evict`=0.
  - Otherwise choose a victim: the lowest-numbered invalid way; if all ways are valid, the PLRU way.
  - Install {1, `req_dirty`, `req_tag`} in the victim, touch PLRU, `rsp_hit`=0.
  - `rsp_evict`/`rsp_evict_dirty`/`rsp_evict_tag` reflect the victim's prior contents; `rsp_evict`=0 if the victim was invalid.
- **INVAL**: on a hit, clear valid and dirty of that way; PLRU unchanged; `rsp_hit` reports the match.
- **PLRU rules**
  - Node bit = 0 means the victim lies in the lower half.
  - Touching way w sets every node on w's path to point away from w.
  - Bits are stored heap-ordered: node 0 is the root; children of node n are 2n+1 and 2n+2.
- **Multiple hits**: cannot arise through legal use. If they occur, the lowest-numbered matching way wins.

## Timing
- Reset values: `req_ready`=0, `init_busy`=1, `rsp_valid`=0, and all other response outputs 0.
- The clear sweep takes exactly `SETS` cycles after `reset` deasserts. `req_ready` rises in the cycle after the write to `SETS-1`.
- Latency is 1: a request accepted in cycle N gives `rsp_valid`=1 in N+1. Throughput is one request per cycle.
- Back-to-back requests to the same set see the previous update; no bubble is inserted.
- There is no response backpressure; the consumer must take `rsp_*` in the `rsp_valid` cycle.
- Response outputs other than `rsp_valid` hold their last value when `rsp_valid`=0.
- Reset asserted mid-sweep or mid-request:
  - Any in-flight response is dropped (`rsp_valid`=0 next cycle).
  - The sweep restarts at set 0.
- `req_valid` during CLEAR is ignored and is not queued.

## Structure
- `cache_definitions_pkg` gains:
  - the `tag_op_e` enum (RD/WR/FILL/INVAL);
  - `sa_tag_entry_t` {valid, dirty, tag}, parameterised via localparam widths;
  - the PLRU helper functions `plru_victim` and `plru_touch`.
- One sub-module, `plru_tree`: combinational victim selection and touch-update for `WAYS-1` bits. It is instantiated once on the addressed set.
- Storage is one register array per way plus a PLRU array, all indexed by `req_index` or `clr_idx`.

## Test plan
All scenarios use WAYS=4, SETS=16, TAG_W=8.
- **Reset/clear**: assert `reset` for 3 cycles, then deassert. Expect `init_busy` high for exactly 16 cycles and `req_ready` high at cycle 17. An RD to any set then misses.
- **Fill to capacity**: FILL tags 0x10, 0x11, 0x12, 0x13 into set 5.
  - Expect `rsp_way` 0, 1, 2, 3 and `rsp_evict`=0 each time.
  - RD of 0x12 in set 5 then gives hit, way 2.
- **PLRU eviction**: after the fills, RD of 0x10 (touch way 0), then FILL 0x20.
  - Expect the victim to be way 2 (tree after the touches), `rsp_evict`=1, `rsp_evict_tag`=0x12.
- **Dirty/evict**: WR hit on 0x11, then force it to become the victim with FILL of a new tag.
  - Expect `rsp_evict_dirty`=1 and `rsp_evict_tag`=0x11.
- **INVAL**: INVAL 0x13 in set 5 gives `rsp_hit`=1.
  - The next FILL 0x30 to set 5 takes way 3 (the invalid way) with `rsp_evict`=0.
- **Reset mid-stream**: issue back-to-back RDs and assert `reset` in the same cycle as an accept.
  - Expect `rsp_valid`=0 next cycle and a full 16-cycle sweep.
  - All sets then miss.
